// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and helpers for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int BYTE_OFF_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // An access is aligned when the low size bits of the byte offset are zero.
  function automatic logic misaligned(input logic [BYTE_OFF_W-1:0] offset, input logic [1:0] size);
    logic [BYTE_OFF_W-1:0] mask;
    mask = 3'((4'b0001 << size) - 4'b0001);
    return (offset & mask) != '0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load extract/extend and store byte-merge within one doubleword
import lsu_pkg::*;

module lsu_align #(
  parameter int N = 64
) (
  input  logic [1:0]            size,
  input  logic [BYTE_OFF_W-1:0] offset,
  input  logic                  sign_ext,
  input  logic [N-1:0]          read_data,
  input  logic [N-1:0]          write_data,
  output logic [N-1:0]          load_data,
  output logic [N-1:0]          merge_data
);

  logic [N-1:0] shifted;
  logic [N-1:0] wshift;
  logic [N-1:0] dmask;
  logic [7:0]   bmask;

  always_comb begin
    shifted   = read_data >> {offset, 3'b000};
    load_data = shifted;
    case (size)
      SZ_B:    load_data = {{(N-8){sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = {{(N-16){sign_ext & shifted[15]}}, shifted[15:0]};
      SZ_W:    load_data = {{(N-32){sign_ext & shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  // Byte-enable mask for the addressed lanes, expanded to a bit mask for the merge.
  always_comb begin
    bmask = 8'hFF;
    case (size)
      SZ_B:    bmask = 8'h01;
      SZ_H:    bmask = 8'h03;
      SZ_W:    bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
    bmask = bmask << offset;
    dmask = '0;
    for (int i = 0; i < 8; i++) begin
      dmask[8*i +: 8] = {8{bmask[i]}};
    end
    wshift     = write_data << {offset, 3'b000};
    merge_data = (read_data & ~dmask) | (wshift & dmask);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator with byte/half/word/doubleword access
// Optional performance counters enabled by defining LSU_PERF_CNT_EN.
import lsu_pkg::*;

module load_store_unit #(
  parameter int N        = 64,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic         ReqWrite,
  input  logic [1:0]   ReqSize,
  input  logic         ReqSigned,
  input  logic [N-1:0] ReqAddress,
  input  logic [N-1:0] ReqWriteData,
  output logic         RespValid,
  output logic [N-1:0] RespData,
  output logic         RespError,
  output logic [N-1:0] MemAddress,
  output logic [N-1:0] MemWriteData,
  output logic         MemoryRead,
  output logic         MemoryWrite,
  input  logic [N-1:0] MemReadData,
  output logic [31:0]  LoadCount,
  output logic [31:0]  StoreCount
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(READ_LAT - 1);

  lsu_state_t            state;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic [BYTE_OFF_W-1:0] off_q;
  logic [N-1:0]          wdata_q;
  logic [CW-1:0]         cnt;
  logic                  req_err;
  logic [N-1:0]          load_data;
  logic [N-1:0]          merge_data;

  assign req_err = misaligned(ReqAddress[BYTE_OFF_W-1:0], ReqSize) ||
                   ((ReqAddress >> BYTE_OFF_W) >= N'(DEPTH));

  lsu_align #(.N(N)) u_align (
    .size       (size_q),
    .offset     (off_q),
    .sign_ext   (sign_q),
    .read_data  (MemReadData),
    .write_data (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      ReqReady     <= 1'b1;
      RespValid    <= 1'b0;
      RespError    <= 1'b0;
      RespData     <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      MemoryRead   <= 1'b0;
      MemoryWrite  <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= SZ_B;
      sign_q       <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            ReqReady <= 1'b0;
            write_q  <= ReqWrite;
            size_q   <= ReqSize;
            sign_q   <= ReqSigned;
            off_q    <= ReqAddress[BYTE_OFF_W-1:0];
            wdata_q  <= ReqWriteData;
            cnt      <= '0;
            if (req_err) begin
              state     <= RESP;
              RespValid <= 1'b1;
              RespError <= 1'b1;
              RespData  <= '0;
            end else begin
              MemAddress <= ReqAddress >> BYTE_OFF_W;
              // Full doubleword stores need no read-modify-write.
              if (ReqWrite && ReqSize == SZ_D) begin
                state        <= WR;
                MemoryWrite  <= 1'b1;
                MemWriteData <= ReqWriteData;
              end else begin
                state      <= RD;
                MemoryRead <= 1'b1;
              end
            end
          end
        end
        RD: begin
          if (cnt == LAST) begin
            MemoryRead <= 1'b0;
            if (write_q) begin
              state        <= WR;
              MemoryWrite  <= 1'b1;
              MemWriteData <= merge_data;
            end else begin
              state     <= RESP;
              RespValid <= 1'b1;
              RespData  <= load_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          MemoryWrite <= 1'b0;
          state       <= RESP;
          RespValid   <= 1'b1;
          RespData    <= '0;
        end
        default: begin
          state     <= IDLE;
          ReqReady  <= 1'b1;
          RespValid <= 1'b0;
          RespError <= 1'b0;
          RespData  <= '0;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else if (state == RESP && !RespError) begin
      if (write_q && store_cnt != 32'hFFFF_FFFF) begin
        store_cnt <= store_cnt + 32'd1;
      end
      if (!write_q && load_cnt != 32'hFFFF_FFFF) begin
        load_cnt <= load_cnt + 32'd1;
      end
    end
  end

  assign LoadCount  = load_cnt;
  assign StoreCount = store_cnt;
`else
  assign LoadCount  = 32'd0;
  assign StoreCount = 32'd0;
`endif

endmodule
